// File: rtl/onehot_drain_encoder_pkg.sv
// Shared types and constants for the one-hot / drain index encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package enc_pkg;

  // Per-word encoding behaviour, captured when a word is accepted
  typedef enum logic {
    ENC_ONEHOT = 1'b0,
    ENC_DRAIN  = 1'b1
  } enc_mode_t;

  // IDLE: no word held; EMIT: a beat is presented on the output stream
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Width of the saturating error-beat counter
  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/onehot_drain_encoder_ffs_lsb.sv
// Find-first-set: index of the lowest set bit of i_vec, plus a found flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state, no handshake.
module ffs_lsb #(
  parameter  int WIDTH  = 8,
  localparam int CODE_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  i_vec,
  output logic [CODE_W-1:0] index,
  output logic              found
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        index = CODE_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_drain_encoder.sv
// Turns a request word into binary bit indices on a valid/ready stream (one code, or one per set bit).
// Latency: first beat registered one cycle after accept; drain beats follow on consecutive handshakes.
// Backpressure: out_* held while out_valid && !out_ready; in_ready only when idle or on the final handshake.
module onehot_drain_encoder
  import enc_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int CODE_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CODE_W-1:0]    out_code,
  output logic                 out_last,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t                r_state;
  enc_mode_t             r_mode;
  logic [WIDTH-1:0]      r_pend;
  logic                  r_out_valid;
  logic [CODE_W-1:0]     r_code;
  logic                  r_last;
  logic                  r_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic                  w_hs;
  logic                  w_acc;
  logic                  w_load;
  logic [WIDTH-1:0]      w_pend_nxt;
  enc_mode_t             w_mode_nxt;
  logic [CODE_W-1:0]     w_ffs_idx;
  logic                  w_ffs_found;
  logic                  w_nxt_le1;
  logic                  w_beat_last;
  logic                  w_beat_err;

  assign w_hs  = r_out_valid && out_ready;

  // A new word can land either into an empty block or on the final beat's handshake
  assign in_ready = (r_state == ST_IDLE) || (w_hs && r_last);
  assign w_acc    = in_valid && in_ready;

  // A fresh beat is formed on accept, or when a drain beat that is not the last one is taken
  assign w_load = w_acc || (w_hs && !r_last);

  // Next pending word: the incoming word, or the current one with its lowest set bit retired
  assign w_pend_nxt = w_acc ? in_data : (r_pend & (r_pend - WIDTH'(1)));
  assign w_mode_nxt = w_acc ? enc_mode_t'(mode) : r_mode;

  ffs_lsb #(
    .WIDTH (WIDTH)
  ) u_ffs (
    .i_vec (w_pend_nxt),
    .index (w_ffs_idx),
    .found (w_ffs_found)
  );

  // At most one bit set (true for zero as well): last drain beat, or part of the one-hot legality test
  assign w_nxt_le1 = ((w_pend_nxt & (w_pend_nxt - WIDTH'(1))) == '0);

  // Beat flags: one-hot words are always single-beat and flag anything not exactly one bit;
  // drain only flags the empty word, which also ends up as a single last beat
  always_comb begin
    w_beat_last = 1'b1;
    w_beat_err  = 1'b0;
    if (w_mode_nxt == ENC_ONEHOT) begin
      w_beat_last = 1'b1;
      w_beat_err  = !(w_ffs_found && w_nxt_le1);
    end else begin
      w_beat_last = w_nxt_le1;
      w_beat_err  = !w_ffs_found;
    end
  end

  // Control FSM with registered beat outputs and the saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= ENC_ONEHOT;
      r_pend      <= '0;
      r_out_valid <= 1'b0;
      r_code      <= '0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state     <= ST_EMIT;
            r_out_valid <= 1'b1;
            r_pend      <= w_pend_nxt;
            r_mode      <= w_mode_nxt;
            r_code      <= w_ffs_idx;
            r_last      <= w_beat_last;
            r_err       <= w_beat_err;
          end
        end
        ST_EMIT: begin
          if (w_load) begin
            r_state     <= ST_EMIT;
            r_out_valid <= 1'b1;
            r_pend      <= w_pend_nxt;
            r_mode      <= w_mode_nxt;
            r_code      <= w_ffs_idx;
            r_last      <= w_beat_last;
            r_err       <= w_beat_err;
          end else if (w_hs) begin
            // Final beat taken with nothing new behind it
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_pend      <= '0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase

      if (w_hs && r_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_code  = r_code;
  assign out_last  = r_last;
  assign out_err   = r_err;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_onehot_drain_encoder.sv
// Directed bench for onehot_drain_encoder: one-hot, drain, backpressure, saturation, mid-word reset.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns after it.
// Backpressure: out_ready driven explicitly per step.
module tb_onehot_drain_encoder;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  logic       out_err;
  logic [7:0] err_count;

  int n_chk;
  int n_err;

  onehot_drain_encoder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for the next falling edge, then settle before sampling
  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int code, input int last, input int err);
    chk({tag, ".valid"}, 32'(out_valid), 1);
    chk({tag, ".code"},  32'(out_code),  32'(code));
    chk({tag, ".last"},  32'(out_last),  32'(last));
    chk({tag, ".err"},   32'(out_err),   32'(err));
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset state
    nstep();
    nstep();
    chk("rst.valid",  32'(out_valid), 0);
    chk("rst.code",   32'(out_code),  0);
    chk("rst.last",   32'(out_last),  0);
    chk("rst.err",    32'(out_err),   0);
    chk("rst.cnt",    32'(err_count), 0);
    chk("rst.ready",  32'(in_ready),  1);
    rst = 1'b0;

    // ONEHOT 0010_0000 -> code 5
    nstep();
    mode = 1'b0; in_valid = 1'b1; in_data = 8'b0010_0000; out_ready = 1'b1;
    nstep();
    in_data = 8'b0100_0100;
    chk_beat("oh5", 5, 1, 0);
    chk("oh5.ready", 32'(in_ready), 1);
    chk("oh5.cnt", 32'(err_count), 0);

    // ONEHOT two bits -> lowest index, err
    nstep();
    in_data = 8'h00;
    chk_beat("oh44", 2, 1, 1);
    chk("oh44.cnt", 32'(err_count), 0);

    // ONEHOT zero word
    nstep();
    in_valid = 1'b0;
    chk_beat("oh00", 0, 1, 1);
    chk("oh00.cnt", 32'(err_count), 1);

    nstep();
    chk("idle1.valid", 32'(out_valid), 0);
    chk("idle1.cnt",   32'(err_count), 2);
    chk("idle1.ready", 32'(in_ready),  1);

    // DRAIN 1001_0010 -> 1, 4, 7; second word offered on the final beat
    mode = 1'b1; in_valid = 1'b1; in_data = 8'b1001_0010;
    nstep();
    in_valid = 1'b0;
    chk_beat("dr.b1", 1, 0, 0);
    chk("dr.b1.ready", 32'(in_ready), 0);
    nstep();
    chk_beat("dr.b4", 4, 0, 0);
    nstep();
    mode = 1'b1; in_valid = 1'b1; in_data = 8'b0000_0110;
    chk_beat("dr.b7", 7, 1, 0);
    chk("dr.b7.ready", 32'(in_ready), 1);

    // Second word's first beat follows immediately; then hold with out_ready low
    nstep();
    in_valid = 1'b0; out_ready = 1'b0;
    chk_beat("bp.c1", 1, 0, 0);
    nstep();
    mode = 1'b0; in_data = 8'hFF;
    chk_beat("bp.hold1", 1, 0, 0);
    nstep();
    mode = 1'b1; in_valid = 1'b1;
    chk_beat("bp.hold2", 1, 0, 0);
    chk("bp.ready", 32'(in_ready), 0);
    nstep();
    in_valid = 1'b0; out_ready = 1'b1;
    chk_beat("bp.hold3", 1, 0, 0);
    nstep();
    chk_beat("bp.c2", 2, 1, 0);
    nstep();
    chk("idle2.valid", 32'(out_valid), 0);
    chk("idle2.cnt",   32'(err_count), 2);

    // 300 back-to-back ONEHOT zero words -> saturation at 255
    mode = 1'b0; in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
    for (int i = 1; i < 300; i++) begin
      nstep();
      if (i == 10) begin
        chk_beat("sat.i10", 0, 1, 1);
        chk("sat.i10.cnt", 32'(err_count), 11);
      end
      if (i == 253) chk("sat.i253.cnt", 32'(err_count), 254);
      if (i == 254) chk("sat.i254.cnt", 32'(err_count), 255);
      if (i == 255) chk("sat.i255.cnt", 32'(err_count), 255);
    end
    nstep();
    in_valid = 1'b0;
    chk("sat.end.cnt", 32'(err_count), 255);
    nstep();
    chk("sat.idle.cnt",   32'(err_count), 255);
    chk("sat.idle.valid", 32'(out_valid), 0);

    // Mid-drain reset after the second of four beats
    mode = 1'b1; in_valid = 1'b1; in_data = 8'b1010_1010;
    nstep();
    in_valid = 1'b0;
    chk_beat("mr.b1", 1, 0, 0);
    nstep();
    chk_beat("mr.b3", 3, 0, 0);
    nstep();
    chk_beat("mr.b5", 5, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("mr.rst.valid", 32'(out_valid), 0);
    chk("mr.rst.code",  32'(out_code),  0);
    chk("mr.rst.cnt",   32'(err_count), 0);
    nstep();
    rst = 1'b0;
    nstep();
    chk("mr.rel.ready", 32'(in_ready),  1);
    chk("mr.rel.valid", 32'(out_valid), 0);
    mode = 1'b1; in_valid = 1'b1; in_data = 8'b0000_1100;
    nstep();
    in_valid = 1'b0;
    chk_beat("mr.n2", 2, 0, 0);
    nstep();
    chk_beat("mr.n3", 3, 1, 0);
    nstep();
    chk("mr.idle.valid", 32'(out_valid), 0);
    chk("mr.idle.cnt",   32'(err_count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/onehot_drain_encoder.md
# onehot_drain_encoder

Parametrised, handshaked successor to the team's 8-to-3 one-hot encoder. It accepts a WIDTH-bit request word and emits binary indices on a registered valid/ready stream, in one of two modes:
- ONEHOT: a single code per word, with an error flag for illegal inputs.
- DRAIN: one code per set bit, LSB first, with a last marker.

It sits between request/status collectors and index-consuming logic such as arbiters, interrupt dispatch and FIFO pointers.

## Interface
- WIDTH, 8: request word width, ≥2.
- CODE_W, $clog2(WIDTH): derived localparam; not overridable.
- clk  in  1: clock; all state changes on rising edge.
- rst  in  1: asynchronous, active-high reset.
- mode  in  1: 0 = ONEHOT, 1 = DRAIN; sampled only on input accept.
- in_valid  in  1: request word valid.
- in_ready  out  1: block can accept a word.
- in_data  in  WIDTH: request word.
- out_valid  out  1: output beat valid.
- out_ready  in  1: consumer accepts beat.
- out_code  out  CODE_W: bit index.
- out_last  out  1: final beat of current word.
- out_err  out  1: beat reports an illegal/empty word.
- err_count  out  8: saturating count of accepted err beats.

## Operation
- States: IDLE (no word held) and EMIT (beat presented on out_*).
- Accept: in_valid && in_ready. On accept:
  - in_data is latched into pend.
  - mode is latched into mode_q.
  - State becomes EMIT.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational and allows a back-to-back accept on the final handshake.
- Zero word (either mode): one beat, code 0, err=1, last=1.
- ONEHOT mode:
  - One beat only.
  - code = index of lowest set bit.
  - err=1 iff popcount(word) ≠ 1.
  - last=1.
- DRAIN mode:
  - One beat per set bit, ascending index.
  - err=0.
  - last=1 on the beat for the highest set bit.
  - On each non-last handshake, the lowest set bit of pend is cleared and the next beat presents the new lowest bit.
- Final handshake without a new accept: return to IDLE.
- Final handshake with a new accept: stay in EMIT with the new word.
- err_count increments by 1 on each handshaken beat with out_err=1. It saturates at 255 and never wraps.
- mode and in_data changes while no accept is occurring have no effect.

## Timing
- Reset values:
  - State IDLE, so in_ready=1.
  - out_valid=0, out_code=0, out_last=0, out_err=0, err_count=0, pend=0.
- Latency: out_valid rises in the cycle after accept. out_code, out_last and out_err are registered.
- Backpressure: while out_valid && !out_ready, all out_* are held stable.
- Throughput:
  - ONEHOT: one word per cycle with out_ready held high.
  - DRAIN: k beats in k consecutive cycles for a k-bit word, with the next word accepted on the k-th handshake.
- out_valid drops the cycle after a final handshake unless a new word was accepted in that same cycle.
- Reset asserted mid-word: all outputs go to reset values immediately (asynchronously), the pending word is discarded and err_count clears.
- WIDTH not a power of two: codes ≥ WIDTH never occur.

## Structure
- Package enc_pkg:
  - typedef enum enc_mode_t {ENC_ONEHOT=0, ENC_DRAIN=1}.
  - typedef enum state_t {ST_IDLE, ST_EMIT}.
  - ERR_CNT_W=8.
- Sub-module ffs_lsb (parameter WIDTH): combinational find-first-set.
  - Outputs index[CODE_W-1:0] and found.
  - Used on the next-pend value to form the registered code.
- The last flag is computed as (pend & (pend-1)) == 0. The single-hot check uses the same expression on in_data.

## Test plan
- Reset, then ONEHOT with in_data=8'b0010_0000, out_ready=1 → next cycle: code=5, last=1, err=0; in_ready stays 1.
- ONEHOT with 8'b0100_0100 → one beat: code=2, err=1, last=1; err_count=1. With 8'h00 → code=0, err=1; err_count=2.
- DRAIN with 8'b1001_0010, out_ready=1 → beats code 1, 4, 7 in 3 consecutive cycles, last only on 7. A second word offered during beat 7 is accepted on that cycle and its first beat follows immediately.
- DRAIN with 8'b0000_0110 and out_ready low for 3 cycles → code=1 held stable until out_ready; then code=2, last=1. mode toggled during the hold is ignored.
- 300 back-to-back ONEHOT zero words → err_count saturates at 255.
- rst asserted mid-DRAIN (after the second of four beats) → out_valid=0 immediately, in_ready=1 after release, and the next word drains from its own lowest bit.
